// File: rtl/apb_req_master.sv
// APB initiator: one valid/ready request becomes one APB transfer and one response.
// Optional access timeout enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  tmo_hit;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter sits at zero outside ACCESS, so it is clear on every entry.
  always_ff @(posedge pclk) begin
    if (!preset_n || state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else if (!pready_i) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  assign tmo_hit = (state_q == ACCESS) && !pready_i &&
                   (tmo_cnt_q == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            paddr_q     <= req_addr_i;
            pwrite_q    <= req_write_i;
            pwdata_q    <= req_wdata_i;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
            rsp_err_q   <= pslverr_i;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end else if (tmo_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with an APB slave model and response scoreboard.
// Timeout scenarios run when APB_REQ_MASTER_TIMEOUT_EN is defined.
module tb_apb_req_master;

  logic        pclk;
  logic        preset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks;
  int   failures;

  int          slv_waits;
  int          slv_emode;
  logic [31:0] slv_rdata;
  int          acc_cnt;

  apb_req_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .paddr_o    (paddr_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave: ready after slv_waits wait states of the current ACCESS phase.
  always @(posedge pclk) begin
    if (!preset_n) acc_cnt <= 0;
    else if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready_i  = psel_o && penable_o && (acc_cnt == slv_waits);
  assign prdata_i  = slv_rdata;
  assign pslverr_i = (slv_emode == 1) ? pready_i :
                     (slv_emode == 2) ? (psel_o && penable_o && !pready_i) :
                     1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer: drive request, follow APB phases, compare response, handshake.
  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input int waits, input int emode,
                      input logic [31:0] rd, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_lat,
                      input int exp_pen, input int bp);
    rsp_t r;
    int   cyc;
    int   pen;
    logic addr_ok;
    logic setup_ok;
    logic hold_ok;
    slv_waits = waits;
    slv_emode = emode;
    slv_rdata = rd;
    exp_q.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge pclk);
    chk({tag, "_ready_idle"}, req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    req_wdata_i = d;
    cyc = 0;
    pen = 0;
    addr_ok  = 1'b1;
    setup_ok = 1'b0;
    while (cyc < 2000) begin
      @(negedge pclk);
      req_valid_i = 1'b0;
      req_addr_i  = ~a;
      req_wdata_i = ~d;
      cyc++;
      if (rsp_valid_o) break;
      if (cyc == 1)
        setup_ok = psel_o && !penable_o && !req_ready_o;
      if (penable_o) pen++;
      if (paddr_o !== a || pwrite_o !== w || pwdata_o !== d || !psel_o)
        addr_ok = 1'b0;
    end
    chk({tag, "_setup"}, setup_ok, 1'b1);
    chk({tag, "_addr_stable"}, addr_ok, 1'b1);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_penable_cycles"}, pen, exp_pen);
    chk({tag, "_psel_resp"}, {psel_o, penable_o, req_ready_o}, 3'b000);
    if (rsp_valid_o && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk({tag, "_rdata"}, rsp_rdata_o, r.rdata);
      chk({tag, "_err"}, rsp_err_o, r.err);
    end else begin
      chk({tag, "_rsp_seen"}, rsp_valid_o, 1'b1);
    end
    hold_ok = 1'b1;
    req_valid_i = (bp > 0);
    req_addr_i  = 32'h0000_0F00;
    for (int i = 0; i < bp; i++) begin
      @(negedge pclk);
      if (!rsp_valid_o || rsp_rdata_o !== exp_rd || rsp_err_o !== exp_err ||
          req_ready_o || psel_o)
        hold_ok = 1'b0;
    end
    if (bp > 0) chk({tag, "_bp_hold"}, hold_ok, 1'b1);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge pclk);
    rsp_ready_i = 1'b0;
    chk({tag, "_done"}, {rsp_valid_o, req_ready_o, psel_o}, 3'b010);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    preset_n    = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    slv_waits   = 0;
    slv_emode   = 0;
    slv_rdata   = '0;
    repeat (3) @(negedge pclk);
    chk("rst_ctrl", {req_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o},
        5'b10000);
    chk("rst_data", {paddr_o, pwdata_o}, 64'h0);
    chk("rst_rsp", {rsp_rdata_o, rsp_err_o}, 33'h0);
    preset_n = 1'b1;

    xfer("wr0", 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 0, 32'hFFFF_FFFF,
         32'h0, 1'b0, 3, 1, 0);
    xfer("rd3w", 32'h0000_0024, 1'b0, 32'h0, 3, 0, 32'h1234_5678,
         32'h1234_5678, 1'b0, 6, 4, 0);
    xfer("rd_err", 32'h0000_0030, 1'b0, 32'h0, 1, 1, 32'hCAFE_0001,
         32'hCAFE_0001, 1'b1, 4, 2, 0);
    xfer("rd_pulse", 32'h0000_0034, 1'b0, 32'h0, 2, 2, 32'h0BAD_F00D,
         32'h0BAD_F00D, 1'b0, 5, 3, 0);
    xfer("wr_bp", 32'h0000_0040, 1'b1, 32'h5555_AAAA, 1, 0, 32'h1111_1111,
         32'h0, 1'b0, 4, 2, 5);
    xfer("rd_after", 32'hFFFF_FFFC, 1'b0, 32'h0, 0, 0, 32'h8000_0001,
         32'h8000_0001, 1'b0, 3, 1, 0);

    // Reset while the slave holds the bus in ACCESS.
    slv_waits = 1000;
    slv_emode = 0;
    @(negedge pclk);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h0000_0050;
    req_write_i = 1'b1;
    req_wdata_i = 32'h7777_7777;
    @(negedge pclk);
    req_valid_i = 1'b0;
    @(negedge pclk);
    chk("rst_mid_access", {psel_o, penable_o}, 2'b11);
    preset_n = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    chk("rst_mid_ctrl", {psel_o, penable_o, rsp_valid_o, req_ready_o},
        4'b0001);
    chk("rst_mid_addr", paddr_o, 32'h0);
    begin
      logic any_rsp;
      any_rsp = 1'b0;
      repeat (6) begin
        @(negedge pclk);
        if (rsp_valid_o || psel_o) any_rsp = 1'b1;
      end
      chk("rst_mid_no_rsp", any_rsp, 1'b0);
    end

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    xfer("tmo_abort", 32'h0000_0060, 1'b0, 32'h0, 1000, 0, 32'h9999_9999,
         32'h0, 1'b1, 6, 4, 0);
    xfer("tmo_edge", 32'h0000_0064, 1'b0, 32'h0, 3, 0, 32'h4242_4242,
         32'h4242_4242, 1'b0, 6, 4, 0);
`else
    xfer("long_wait", 32'h0000_0060, 1'b0, 32'h0, 20, 0, 32'h9999_9999,
         32'h9999_9999, 1'b0, 23, 21, 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
Name: apb_req_master

Overview:
APB initiator bridge. Converts a simple valid/ready request/response port into single APB transfers on the codebase's APB bus (Master side: paddr, psel, penable, pwrite, pwdata out; pready, prdata, pslverr in). It sits between an internal controller (debug/DMA/config engine) and an APB slave or APB demux. It handles one transfer at a time, with no pipelining across transfers.

Parameters:
ADDR_WIDTH, 32, width of req_addr_i / paddr_o
DATA_WIDTH, 32, width of write/read data
TIMEOUT_CYCLES, 256, max ACCESS cycles before abort (used only with APB_REQ_MASTER_TIMEOUT_EN; must be >= 1)

Ports:
pclk  in  1  clock
preset_n  in  1  synchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  ADDR_WIDTH  transfer address
req_write_i  in  1  1=write, 0=read
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes/aborts)
rsp_err_o  out  1  pslverr or timeout
paddr_o  out  ADDR_WIDTH  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pready_i  in  1  APB ready
prdata_i  in  DATA_WIDTH  APB read data
pslverr_i  in  1  APB slave error

Behaviour:
- Single clock pclk, reset synchronous active-low on preset_n; all state/outputs registered.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o=1. On req_valid_i at edge → capture addr/write/wdata into paddr_o/pwrite_o/pwdata_o, go SETUP. Otherwise stay.
- SETUP (one cycle): psel_o=1, penable_o=0, req_ready_o=0; pready_i ignored; go ACCESS.
- ACCESS: psel_o=1, penable_o=1. Sample pready_i each edge; if 0, stay (wait state). If 1: rsp_rdata_o = pwrite_o ? 0 : prdata_i, rsp_err_o = pslverr_i, go RESP.
- RESP: psel_o=0, penable_o=0, rsp_valid_o=1; hold rsp_* stable until rsp_ready_i sampled 1, then rsp_valid_o=0 → IDLE. Next request can be accepted only in IDLE (no same-cycle RESP→accept).
- paddr_o/pwrite_o/pwdata_o constant from SETUP through the end of ACCESS; they retain last values in IDLE/RESP.
- Latency: accept at edge N → SETUP cycle N+1, ACCESS N+2; pready high at edge of cycle M → rsp_valid_o from M+1. Zero-wait transfer: accept-to-rsp_valid = 3 cycles.
- pslverr_i sampled only in ACCESS with pready_i=1; ignored otherwise.
- Reset mid-operation: preset_n=0 at any edge forces the reset values; the in-flight transfer is dropped and no response is produced.
- The requester must hold req_* stable while req_valid_i=1 and unaccepted; captured values are used, so later changes are harmless.

Optional Feature:
APB_REQ_MASTER_TIMEOUT_EN
- With macro: counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments each ACCESS cycle with pready_i=0. If the TIMEOUT_CYCLES-th ACCESS cycle ends with pready_i=0, abort: go RESP with rsp_err_o=1 and rsp_rdata_o=0; psel_o/penable_o drop the following cycle. pready_i=1 in that final cycle completes normally (no abort).
- Without macro: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Write addr 0x0000_0010 data 0xDEAD_BEEF, slave pready=1 always → SETUP then ACCESS with correct paddr/pwdata/pwrite=1; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 0x24, slave inserts 3 wait states then prdata=0x1234_5678 → penable high 4 cycles, addr stable; rsp_rdata=0x1234_5678 at rsp_valid.
- Read with pslverr=1 on the ready cycle → rsp_err=1, rsp_rdata=prdata; pslverr pulsed while pready=0 → rsp_err=0.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_* held, req_ready=0, psel=0; new request accepted only after the handshake plus IDLE.
- Assert preset_n=0 during ACCESS → next edge psel=penable=0, rsp_valid=0, req_ready=1; no response emitted.
- With APB_REQ_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never ready → exactly 4 ACCESS cycles, then rsp_err=1, rsp_rdata=0. The same test with pready on cycle 4 → normal completion.
